// File: rtl/pc_lut_pkg.sv
// Shared branch-target LUT definitions: widths, index constants, offset table,
// the target lookup used by both the forward LUT and the offset encoder, and FSM states.
package pc_lut_pkg;

  localparam int B      = 3;
  localparam int CODE_W = B + 1;
  localparam int TGT_W  = B + 3;
  localparam int LUT_N  = 8;

  localparam logic [CODE_W-1:0] IDX_P2  = 4'd0;
  localparam logic [CODE_W-1:0] IDX_M2  = 4'd1;
  localparam logic [CODE_W-1:0] IDX_P4  = 4'd2;
  localparam logic [CODE_W-1:0] IDX_M4  = 4'd3;
  localparam logic [CODE_W-1:0] IDX_P8  = 4'd4;
  localparam logic [CODE_W-1:0] IDX_M8  = 4'd5;
  localparam logic [CODE_W-1:0] IDX_P16 = 4'd6;
  localparam logic [CODE_W-1:0] IDX_M16 = 4'd7;

  typedef logic signed [TGT_W-1:0] tgt_t;

  localparam tgt_t LUT_TABLE [LUT_N] = '{
    6'sd2, -6'sd2, 6'sd4, -6'sd4, 6'sd8, -6'sd8, 6'sd16, -6'sd16
  };

  // Indices beyond the table map to a zero displacement.
  function automatic tgt_t lut_target(input logic [CODE_W-1:0] idx);
    tgt_t t;
    if (idx < CODE_W'(LUT_N)) begin
      t = LUT_TABLE[idx[$clog2(LUT_N)-1:0]];
    end else begin
      t = '0;
    end
    return t;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/offset_select.sv
// Greedy code choice: picks the largest-magnitude LUT entry not overshooting the
// remaining displacement, and reports the remainder after taking it.
module offset_select
  import pc_lut_pkg::*;
#(
  parameter int W = 12
) (
  input  logic signed [W:0]        rem_i,
  output logic        [CODE_W-1:0] code_o,
  output logic signed [W:0]        next_rem_o,
  output logic                     is_last_o
);

  localparam logic signed [W:0] P16 = (W+1)'(16);
  localparam logic signed [W:0] M16 = -(W+1)'(16);
  localparam logic signed [W:0] P8  = (W+1)'(8);
  localparam logic signed [W:0] M8  = -(W+1)'(8);
  localparam logic signed [W:0] P4  = (W+1)'(4);
  localparam logic signed [W:0] M4  = -(W+1)'(4);
  localparam logic signed [W:0] M2  = -(W+1)'(2);

  tgt_t              tgt_s;
  logic signed [W:0] tgt_ext_s;

  // Priority chain from largest magnitude down; +2 covers rem==2 and the idle rem==0.
  always_comb begin
    code_o = IDX_P2;
    if (rem_i >= P16) begin
      code_o = IDX_P16;
    end else if (rem_i <= M16) begin
      code_o = IDX_M16;
    end else if (rem_i >= P8) begin
      code_o = IDX_P8;
    end else if (rem_i <= M8) begin
      code_o = IDX_M8;
    end else if (rem_i >= P4) begin
      code_o = IDX_P4;
    end else if (rem_i <= M4) begin
      code_o = IDX_M4;
    end else if (rem_i == M2) begin
      code_o = IDX_M2;
    end else begin
      code_o = IDX_P2;
    end
  end

  assign tgt_s      = lut_target(code_o);
  assign tgt_ext_s  = {{(W+1-TGT_W){tgt_s[TGT_W-1]}}, tgt_s};
  assign next_rem_o = rem_i - tgt_ext_s;
  assign is_last_o  = (next_rem_o == '0);

endmodule

// File: rtl/pc_offset_encoder.sv
// Turns a signed PC displacement into a handshaked stream of LUT codes whose
// targets sum to it; odd displacements are rejected with err on the done pulse.
module pc_offset_encoder
  import pc_lut_pkg::*;
#(
  parameter int W  = 12,
  parameter int CW = 8
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic signed [W-1:0] req_offset,
  output logic                code_valid,
  input  logic                code_ready,
  output logic [CODE_W-1:0]   code,
  output logic                code_last,
  output logic                done,
  output logic                err,
  output logic [CW-1:0]       count
);

  state_e             state_q, state_d;
  logic signed [W:0]  rem_q, rem_d;
  logic [CW-1:0]      count_q, count_d;
  logic               err_q, err_d;

  logic [CODE_W-1:0]  sel_code_s;
  logic signed [W:0]  sel_next_s;
  logic               sel_last_s;

  offset_select #(.W(W)) u_select (
    .rem_i      (rem_q),
    .code_o     (sel_code_s),
    .next_rem_o (sel_next_s),
    .is_last_o  (sel_last_s)
  );

  // Next-state logic: request acceptance, one code per handshake, single-cycle FIN.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rem_d   = {req_offset[W-1], req_offset};
          count_d = '0;
          if (req_offset[0]) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else if (req_offset == '0) begin
            err_d   = 1'b0;
            state_d = FIN;
          end else begin
            err_d   = 1'b0;
            state_d = EMIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (code_ready) begin
          rem_d   = sel_next_s;
          count_d = count_q + CW'(1);
          if (sel_last_s) begin
            state_d = FIN;
          end else begin
            state_d = EMIT;
          end
        end else begin
          state_d = EMIT;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, remainder and result registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign code_valid = (state_q == EMIT);
  assign done       = (state_q == FIN);
  assign code       = sel_code_s;
  assign code_last  = sel_last_s;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_pc_offset_encoder.sv
// Self-checking bench for pc_offset_encoder: directed table, stall and reset-abort
// sequences, then random offsets against a greedy-decomposition reference model.
module tb_pc_offset_encoder;

  logic              Clk;
  logic              Reset_n;
  logic              req_valid;
  logic              req_ready;
  logic signed [11:0] req_offset;
  logic              code_valid;
  logic              code_ready;
  logic [3:0]        code;
  logic              code_last;
  logic              done;
  logic              err;
  logic [7:0]        count;

  int n_cmp;
  int n_fail;
  int exp_q[$];
  int stall_pat[6];

  pc_offset_encoder #(.W(12), .CW(8)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_offset (req_offset),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code       (code),
    .code_last  (code_last),
    .done       (done),
    .err        (err),
    .count      (count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no end, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference: repeatedly take the largest power-of-two step (16,8,4,2) toward zero.
  function automatic void build_exp(input int off);
    int rem;
    bit took;
    exp_q.delete();
    if (off % 2 != 0) return;
    rem = off;
    while (rem != 0) begin
      took = 1'b0;
      for (int k = 3; k >= 0; k--) begin
        int mag;
        mag = 2 << k;
        if (!took && rem >= mag) begin
          exp_q.push_back(2 * k);
          rem -= mag;
          took = 1'b1;
        end else if (!took && rem <= -mag) begin
          exp_q.push_back(2 * k + 1);
          rem += mag;
          took = 1'b1;
        end
      end
    end
  endfunction

  // Issue one request and follow it to the done pulse; mode 0 always ready,
  // 1 random back-pressure, 2 the fixed stall_pat sequence.
  task automatic run_req(input int off, input int mode, input bit exp_err, input int exp_lat);
    int  cyc;
    int  nexp;
    int  ncode;
    bit  fin;
    bit  stalled;
    logic [3:0] pcode;
    logic       plast;
    logic       rdy;
    nexp    = exp_q.size();
    ncode   = 0;
    fin     = 1'b0;
    stalled = 1'b0;
    pcode   = 4'd0;
    plast   = 1'b0;
    @(negedge Clk);
    chk("req_ready_before", req_ready, 1);
    req_valid  = 1'b1;
    req_offset = 12'(off);
    code_ready = 1'b1;
    @(negedge Clk);
    req_valid  = 1'b0;
    req_offset = 12'(12'h5a5);
    cyc = 1;
    while (!fin && cyc < 1000) begin
      if (done) begin
        chk("done_err", err, exp_err);
        chk("done_count", count, nexp);
        chk("done_no_code_valid", code_valid, 0);
        chk("done_req_ready_low", req_ready, 0);
        chk("codes_left", exp_q.size(), 0);
        if (exp_lat > 0) chk("done_latency", cyc, exp_lat);
        fin = 1'b1;
      end else if (code_valid) begin
        if (stalled) begin
          chk("stall_code_stable", code, pcode);
          chk("stall_last_stable", code_last, plast);
        end
        if (exp_q.size() == 0) begin
          chk("extra_code", 1, 0);
          rdy = 1'b1;
        end else begin
          chk("code", code, exp_q[0]);
          chk("code_last", code_last, (exp_q.size() == 1));
          chk("req_ready_busy", req_ready, 0);
          if (mode == 0) rdy = 1'b1;
          else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
          else rdy = (ncode < 6) ? stall_pat[ncode][0] : 1'b1;
          if (rdy) void'(exp_q.pop_front());
        end
        ncode++;
        stalled = !rdy;
        pcode   = code;
        plast   = code_last;
        code_ready = rdy;
      end else begin
        chk("busy_progress", {code_valid, done}, 2'b10);
      end
      @(negedge Clk);
      cyc++;
    end
    if (!fin) begin
      chk("timeout_no_done", 0, 1);
    end else begin
      chk("done_one_cycle", done, 0);
      chk("req_ready_after", req_ready, 1);
      chk("err_held", err, exp_err);
      chk("count_held", count, nexp);
    end
  endtask

  typedef struct {
    int off;
    int mode;
    int n;
    int codes;
    bit err;
    int lat;
  } vec_t;

  vec_t vt[6];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    stall_pat = '{1, 0, 0, 1, 0, 1};
    vt[0] = '{off: 22,  mode: 0, n: 3, codes: 'h620,  err: 1'b0, lat: 4};
    vt[1] = '{off: -30, mode: 0, n: 4, codes: 'h7531, err: 1'b0, lat: 5};
    vt[2] = '{off: 5,   mode: 0, n: 0, codes: 0,      err: 1'b1, lat: 1};
    vt[3] = '{off: 0,   mode: 0, n: 0, codes: 0,      err: 1'b0, lat: 1};
    vt[4] = '{off: 40,  mode: 2, n: 3, codes: 'h664,  err: 1'b0, lat: 7};
    vt[5] = '{off: -3,  mode: 0, n: 0, codes: 0,      err: 1'b1, lat: 1};

    Reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_offset = 12'sd0;
    code_ready = 1'b0;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_code_valid", code_valid, 0);
    chk("rst_code", code, 0);
    chk("rst_code_last", code_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      exp_q.delete();
      for (int j = vt[i].n - 1; j >= 0; j--) exp_q.push_back((vt[i].codes >> (4 * j)) & 'hf);
      run_req(vt[i].off, vt[i].mode, vt[i].err, vt[i].lat);
    end

    // Most negative displacement: 128 steps of -16.
    exp_q.delete();
    for (int j = 0; j < 128; j++) exp_q.push_back(7);
    run_req(-2048, 0, 1'b0, 129);

    // Same request aborted by reset after 10 codes.
    @(negedge Clk);
    req_valid  = 1'b1;
    req_offset = -12'sd2048;
    code_ready = 1'b1;
    @(negedge Clk);
    req_valid = 1'b0;
    repeat (10) @(negedge Clk);
    chk("abort_pre_code_valid", code_valid, 1);
    chk("abort_pre_code", code, 7);
    Reset_n = 1'b0;
    #1;
    chk("abort_code_valid", code_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_count", count, 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge Clk);
      chk("abort_no_done", done, 0);
    end
    Reset_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(0);
    run_req(2, 0, 1'b0, 2);

    // Random offsets with random back-pressure against the reference model.
    for (int i = 0; i < 40; i++) begin
      int off;
      logic signed [11:0] r12;
      if (i % 5 == 4) begin
        r12 = 12'($urandom);
        off = int'(r12);
      end else begin
        off = int'($urandom_range(0, 600)) - 300;
      end
      build_exp(off);
      run_req(off, 1, (off % 2 != 0), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
